// File: rtl/branch_predictor_btb.sv
// Direct-mapped tagged BTB with 2-bit counters predicting branch/JAL targets in IF, trained at EX/MEM.
// Optional return address stack for JALR returns is enabled by defining BP_RAS_EN.
module branch_predictor_btb #(
    parameter int ADDRESS_BITS = 20,
    parameter int INST_WIDTH   = 32,
    parameter int INDEX_BITS   = 6,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] if_inst_PC,
    input  logic [INST_WIDTH-1:0]   if_instruction,
    output logic                    predict_taken,
    output logic [ADDRESS_BITS-1:0] predicted_address,
    input  logic                    exmem_valid,
    input  logic [ADDRESS_BITS-1:0] exmem_inst_PC,
    input  logic [1:0]              exmem_next_PC_sel,
    input  logic                    exmem_ALU_branch,
    input  logic [ADDRESS_BITS-1:0] exmem_target,
    input  logic                    exmem_link,
    input  logic                    exmem_return
);
    localparam int ENTRIES      = 1 << INDEX_BITS;
    localparam int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - 2;
    localparam int RAS_PTR_BITS = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [ENTRIES-1:0]      r_valid;
    logic [ENTRIES-1:0]      r_is_jal;
    logic [TAG_BITS-1:0]     r_tag    [ENTRIES];
    logic [ADDRESS_BITS-1:0] r_target [ENTRIES];
    logic [1:0]              r_ctr    [ENTRIES];

    // ---------------- IF lookup ----------------
    logic [INDEX_BITS-1:0]   w_if_index;
    logic [TAG_BITS-1:0]     w_if_tag;
    logic [6:0]              w_if_opcode;
    logic [ADDRESS_BITS-1:0] w_if_seq_pc;
    logic                    w_if_tag_hit;
    logic                    w_if_br_hit;
    logic                    w_if_jal_hit;
    logic                    w_btb_taken;
    logic                    w_ras_taken;
    logic [ADDRESS_BITS-1:0] w_ras_top;

    assign w_if_index   = if_inst_PC[INDEX_BITS+1:2];
    assign w_if_tag     = if_inst_PC[ADDRESS_BITS-1:INDEX_BITS+2];
    assign w_if_opcode  = if_instruction[6:0];
    assign w_if_seq_pc  = if_inst_PC + ADDRESS_BITS'(4);
    assign w_if_tag_hit = r_valid[w_if_index] && (r_tag[w_if_index] == w_if_tag);
    assign w_if_br_hit  = w_if_tag_hit && !r_is_jal[w_if_index] && (w_if_opcode == OP_BRANCH);
    assign w_if_jal_hit = w_if_tag_hit &&  r_is_jal[w_if_index] && (w_if_opcode == OP_JAL);
    assign w_btb_taken  = w_if_jal_hit || (w_if_br_hit && r_ctr[w_if_index][1]);

    // RAS and BTB predictions are disjoint by opcode, so priority order is immaterial.
    always_comb begin
        predict_taken     = w_btb_taken || w_ras_taken;
        predicted_address = w_if_seq_pc;
        if (w_ras_taken)
            predicted_address = w_ras_top;
        else if (w_btb_taken)
            predicted_address = r_target[w_if_index];
    end

    // ---------------- EX/MEM training ----------------
    logic [INDEX_BITS-1:0]   w_ex_index;
    logic [TAG_BITS-1:0]     w_ex_tag;
    logic                    w_ex_tag_hit;
    logic                    w_wr_en;
    logic [ADDRESS_BITS-1:0] w_wr_target;
    logic [1:0]              w_wr_ctr;
    logic                    w_wr_is_jal;

    assign w_ex_index   = exmem_inst_PC[INDEX_BITS+1:2];
    assign w_ex_tag     = exmem_inst_PC[ADDRESS_BITS-1:INDEX_BITS+2];
    assign w_ex_tag_hit = r_valid[w_ex_index] && (r_tag[w_ex_index] == w_ex_tag);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = r_target[w_ex_index];
        w_wr_ctr    = r_ctr[w_ex_index];
        w_wr_is_jal = 1'b0;
        if (exmem_valid) begin
            case (exmem_next_PC_sel)
                2'b01: begin
                    if (w_ex_tag_hit) begin
                        w_wr_en = 1'b1;
                        if (exmem_ALU_branch) begin
                            w_wr_target = exmem_target;
                            w_wr_ctr    = (r_ctr[w_ex_index] == 2'b11) ? 2'b11 : r_ctr[w_ex_index] + 2'd1;
                        end else begin
                            w_wr_ctr    = (r_ctr[w_ex_index] == 2'b00) ? 2'b00 : r_ctr[w_ex_index] - 2'd1;
                        end
                    end else if (exmem_ALU_branch) begin
                        w_wr_en     = 1'b1;
                        w_wr_target = exmem_target;
                        w_wr_ctr    = 2'b10;
                    end
                end
                2'b10: begin
                    w_wr_en     = 1'b1;
                    w_wr_target = exmem_target;
                    w_wr_ctr    = 2'b11;
                    w_wr_is_jal = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_valid <= '0;
        else if (w_wr_en)
            r_valid[w_ex_index] <= 1'b1;
    end

    // Entry payload needs no reset: it is only observed behind a set valid bit.
    always_ff @(posedge clock) begin
        if (!reset && w_wr_en) begin
            r_tag[w_ex_index]    <= w_ex_tag;
            r_target[w_ex_index] <= w_wr_target;
            r_ctr[w_ex_index]    <= w_wr_ctr;
            r_is_jal[w_ex_index] <= w_wr_is_jal;
        end
    end

`ifdef BP_RAS_EN
    localparam logic [RAS_PTR_BITS:0] RAS_FULL = (RAS_PTR_BITS+1)'(RAS_DEPTH);

    logic [ADDRESS_BITS-1:0] r_ras [RAS_DEPTH];
    logic [RAS_PTR_BITS-1:0] r_ras_ptr;    // next free slot; top is one below
    logic [RAS_PTR_BITS:0]   r_ras_count;
    logic [RAS_PTR_BITS-1:0] w_ras_top_ptr;
    logic [ADDRESS_BITS-1:0] w_ex_link_pc;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_if_is_return;
    logic                    w_unused_inst;

    assign w_ras_top_ptr  = r_ras_ptr - RAS_PTR_BITS'(1);
    assign w_ras_top      = r_ras[w_ras_top_ptr];
    assign w_ex_link_pc   = exmem_inst_PC + ADDRESS_BITS'(4);
    assign w_push         = exmem_valid && exmem_link;
    assign w_pop          = exmem_valid && exmem_return;
    assign w_if_is_return = (w_if_opcode == OP_JALR) && (if_instruction[11:7] == 5'd0) &&
                            ((if_instruction[19:15] == 5'd1) || (if_instruction[19:15] == 5'd5));
    assign w_ras_taken    = w_if_is_return && (r_ras_count != '0);
    assign w_unused_inst  = &{1'b0, if_instruction};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ras_ptr   <= '0;
            r_ras_count <= '0;
        end else if (w_push && w_pop) begin
            r_ras[w_ras_top_ptr] <= w_ex_link_pc;
        end else if (w_push) begin
            // Wrapping pointer overwrites the oldest entry once the stack is full.
            r_ras[r_ras_ptr] <= w_ex_link_pc;
            r_ras_ptr        <= r_ras_ptr + RAS_PTR_BITS'(1);
            if (r_ras_count != RAS_FULL)
                r_ras_count <= r_ras_count + (RAS_PTR_BITS+1)'(1);
        end else if (w_pop && (r_ras_count != '0)) begin
            r_ras_ptr   <= w_ras_top_ptr;
            r_ras_count <= r_ras_count - (RAS_PTR_BITS+1)'(1);
        end
    end
`else
    logic [RAS_PTR_BITS-1:0] w_unused_ras_ptr;
    logic                    w_unused_ras;

    assign w_ras_taken      = 1'b0;
    assign w_ras_top        = '0;
    assign w_unused_ras_ptr = '0;
    assign w_unused_ras     = &{1'b0, exmem_link, exmem_return, if_instruction, w_unused_ras_ptr};
`endif

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised successor to the fetch-stage predictor: a direct-mapped, tagged branch target buffer with a per-entry 2-bit saturating counter. Predicts next fetch PC for conditional branches and JAL in IF, and trains from resolved control-flow at EX/MEM. An optional return address stack also predicts JALR returns. Sits between the fetch PC mux and the EX/MEM pipeline register.

## Interface
- ADDRESS_BITS, 20, PC width.
- INST_WIDTH, 32, instruction width; opcode is bits [6:0].
- INDEX_BITS, 6, BTB index width; 2^INDEX_BITS entries.
- RAS_DEPTH, 4, return stack entries (power of 2, ≥2); used only with BP_RAS_EN.

- clock  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- if_inst_PC  in  ADDRESS_BITS  fetch PC.
- if_instruction  in  INST_WIDTH  fetched instruction.
- predict_taken  out  1  predicted redirect.
- predicted_address  out  ADDRESS_BITS  predicted next PC.
- exmem_valid  in  1  EX/MEM holds a real (non-bubble) instruction.
- exmem_inst_PC  in  ADDRESS_BITS  PC of resolving instruction.
- exmem_next_PC_sel  in  2  00 seq, 01 branch, 10 JAL, 11 JALR.
- exmem_ALU_branch  in  1  branch condition true.
- exmem_target  in  ADDRESS_BITS  resolved target for sel 01/10/11.
- exmem_link  in  1  instruction writes x1/x5 (call).
- exmem_return  in  1  JALR with rs1=x1/x5, rd=x0 (return).

## Operation
- Index = PC[INDEX_BITS+1:2]; tag = PC[ADDRESS_BITS-1:INDEX_BITS+2]. Entry: valid, tag, target, ctr[1:0], is_jal.
- Lookup (combinational): hit = valid & tag match & stored type matches if_instruction opcode (1100011 with is_jal=0, 1101111 with is_jal=1).
  - Branch hit: predict_taken = ctr[1]; JAL hit: predict_taken = 1. Taken → predicted_address = target.
  - Otherwise predict_taken = 0, predicted_address = if_inst_PC + 4 (modulo 2^ADDRESS_BITS).
- Training, only when exmem_valid:
  - sel 01, hit on tag (type ignored): ctr saturating +1 if taken, −1 if not; target overwritten when taken; is_jal←0.
  - sel 01, miss, taken: allocate (overwrite slot): valid=1, tag, target, ctr=10, is_jal=0. Miss not-taken: no write.
  - sel 10: allocate/overwrite with ctr=11, is_jal=1.
  - sel 00/11: BTB unchanged.
- Reset: all valid bits cleared; ctr/target/tag need not reset. RAS pointer and count cleared.

## Timing
- Prediction zero-latency combinational from IF inputs.
- Training writes at the posedge where exmem_valid is sampled; visible to lookup the following cycle. Same-cycle read of a slot being written returns pre-write contents (no bypass).
- Reset asserted mid-operation: next cycle every lookup misses; predict_taken=0, predicted_address=if_inst_PC+4. Outputs are combinational, so no registered reset value beyond this.
- Counter boundaries: 11 +taken stays 11; 00 −not-taken stays 00.

## Configuration
- BP_RAS_EN defined: RAS of RAS_DEPTH targets, trained at EX/MEM when exmem_valid.
  - exmem_link pushes exmem_inst_PC+4.
  - exmem_return pops.
  - Both in one cycle: replace top entry, count unchanged.
  - Push when full: circular overwrite of oldest, count saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - IF: if_instruction opcode 1100111, rd=x0, rs1∈{x1,x5}, count>0 → predict_taken=1, predicted_address=top.
- BP_RAS_EN undefined: no RAS state; exmem_link/exmem_return ignored; JALR always predicts not taken, PC+4.

## Test plan
- Reset, then fetch PC 0x100 with branch opcode → predict_taken=0, predicted_address=0x104.
- Resolve taken branch PC 0x100 target 0x200; next cycle fetch 0x100 → taken, 0x200; two not-taken resolves → ctr 00, predicts 0x104; three taken resolves → ctr saturates 11.
- JAL PC 0x040 target 0x300 resolved; fetch 0x040 with JAL opcode → taken 0x300; same PC with non-JAL opcode → not taken, 0x044.
- Aliasing: PCs 0x100 and 0x100+(4<<INDEX_BITS) map to the same slot; training second evicts first → first misses.
- Same-cycle update and lookup of the same slot → old prediction; updated prediction one cycle later. exmem_valid=0 with sel=10 → no allocate.
- BP_RAS_EN: push 0x014, 0x024, 0x034, 0x044, 0x054 (depth 4); five returns predict 0x054, 0x044, 0x034, 0x024, then not taken. Simultaneous push/pop replaces top.
